// File: rtl/bitserial_pkg.sv
// Shared types and sizing helpers for the bit-serial add/subtract sequencer.
package bitserial_pkg;
  localparam int DEFAULT_WIDTH = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  function automatic int cnt_width(input int w);
    return (w > 1) ? $clog2(w) : 1;
  endfunction
endpackage

// File: rtl/bitserial_add_ctrl_fa_cell.sv
// Single-bit full adder assembled from two half adders and an OR;
// the only combinational datapath of the sequencer.
module ha (
  input  logic a,
  input  logic b,
  output logic sum,
  output logic carry
);
  assign sum   = a ^ b;
  assign carry = a & b;
endmodule

module fa_cell (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic sum,
  output logic carry
);
  logic s1;
  logic c1;
  logic c2;

  ha u_ha0 (.a(a),  .b(b),   .sum(s1),  .carry(c1));
  ha u_ha1 (.a(s1), .b(cin), .sum(sum), .carry(c2));

  assign carry = c1 | c2;
endmodule

// File: rtl/bitserial_add_ctrl.sv
// Bit-serial add/subtract sequencer: reuses one full-adder cell LSB first,
// one bit per clock, behind a start/busy/done handshake.
module bitserial_add_ctrl
  import bitserial_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             sub,
  input  logic [WIDTH-1:0] op_a,
  input  logic [WIDTH-1:0] op_b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic             carry_out
);
  localparam int CNT_W = cnt_width(WIDTH);
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);

  state_t           state;
  logic [CNT_W-1:0] cnt;
  logic [WIDTH-1:0] a_sr;
  logic [WIDTH-1:0] b_sr;
  logic             carry;
  logic             fa_s;
  logic             fa_c;

  fa_cell u_fa (
    .a    (a_sr[0]),
    .b    (b_sr[0]),
    .cin  (carry),
    .sum  (fa_s),
    .carry(fa_c)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      cnt       <= '0;
      a_sr      <= '0;
      b_sr      <= '0;
      carry     <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
      result    <= '0;
      carry_out <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            // Subtraction is a + ~b + 1: invert b and seed the carry with 1.
            a_sr  <= op_a;
            b_sr  <= sub ? ~op_b : op_b;
            carry <= sub;
            cnt   <= '0;
            busy  <= 1'b1;
            state <= RUN;
          end
        end
        RUN: begin
          a_sr   <= a_sr >> 1;
          b_sr   <= b_sr >> 1;
          result <= {fa_s, result[WIDTH-1:1]};
          carry  <= fa_c;
          cnt    <= cnt + 1'b1;
          if (cnt == LAST_BIT) begin
            done      <= 1'b1;
            carry_out <= fa_c;
            state     <= DONE;
          end
        end
        DONE: begin
          done  <= 1'b0;
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: begin
          done  <= 1'b0;
          busy  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_bitserial_add_ctrl.sv
// Directed and random checks of the bit-serial add/subtract sequencer (WIDTH=8).
module tb_bitserial_add_ctrl;
  logic       clk;
  logic       rst_n;
  logic       start;
  logic       sub;
  logic [7:0] op_a;
  logic [7:0] op_b;
  logic       busy;
  logic       done;
  logic [7:0] result;
  logic       carry_out;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;
  int acc_cyc  = 0;

  bitserial_add_ctrl #(.WIDTH(8)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (start),
    .sub      (sub),
    .op_a     (op_a),
    .op_b     (op_b),
    .busy     (busy),
    .done     (done),
    .result   (result),
    .carry_out(carry_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Waits for the sequencer to be idle, then presents one request and lets it be accepted.
  task automatic start_op(input logic [7:0] a, input logic [7:0] b, input logic s, input bit hold);
    int n = 0;
    @(negedge clk);
    while (busy && n < 40) begin
      @(negedge clk);
      n++;
    end
    start = 1'b1;
    op_a  = a;
    op_b  = b;
    sub   = s;
    @(posedge clk);
    #1;
    acc_cyc = cyc;
    if (!hold) start = 1'b0;
  endtask

  task automatic wait_done(input string tag, output int lat);
    int n = 0;
    while (!done && n < 40) begin
      @(posedge clk);
      #1;
      n++;
    end
    lat = cyc - acc_cyc;
    check({tag, "_done_seen"}, 32'(done), 32'd1);
  endtask

  task automatic do_op(input string tag, input logic [7:0] a, input logic [7:0] b,
                       input logic s, input logic [7:0] exp_r, input logic exp_c);
    int lat;
    start_op(a, b, s, 1'b0);
    wait_done(tag, lat);
    check({tag, "_latency"}, 32'(lat), 32'd8);
    check({tag, "_result"}, 32'(result), 32'(exp_r));
    check({tag, "_carry"}, 32'(carry_out), 32'(exp_c));
    @(posedge clk);
    #1;
    check({tag, "_done_one_cycle"}, 32'(done), 32'd0);
  endtask

  initial begin
    int lat;
    int t1;
    int t2;
    bit saw_done;
    logic [7:0] ra;
    logic [7:0] rb;
    logic       rs;
    logic [8:0] ref_sum;
    logic [7:0] ref_r;
    logic       ref_c;

    rst_n = 1'b0;
    start = 1'b0;
    sub   = 1'b0;
    op_a  = '0;
    op_b  = '0;
    repeat (3) @(posedge clk);
    #1;
    check("reset_busy", 32'(busy), 32'd0);
    check("reset_done", 32'(done), 32'd0);
    check("reset_result", 32'(result), 32'd0);
    check("reset_carry", 32'(carry_out), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    do_op("add_00_00", 8'h00, 8'h00, 1'b0, 8'h00, 1'b0);
    do_op("add_ff_01", 8'hFF, 8'h01, 1'b0, 8'h00, 1'b1);
    do_op("add_5a_3c", 8'h5A, 8'h3C, 1'b0, 8'h96, 1'b0);
    do_op("sub_5a_3c", 8'h5A, 8'h3C, 1'b1, 8'h1E, 1'b1);
    do_op("sub_3c_5a", 8'h3C, 8'h5A, 1'b1, 8'hE2, 1'b0);

    // Start pulsed at RUN bit 3 with a changed operand must be ignored.
    start_op(8'h5A, 8'h3C, 1'b0, 1'b0);
    repeat (3) @(posedge clk);
    @(negedge clk);
    start = 1'b1;
    op_a  = 8'h11;
    @(posedge clk);
    #1;
    start = 1'b0;
    check("ign_busy", 32'(busy), 32'd1);
    wait_done("ign", lat);
    check("ign_latency", 32'(lat), 32'd8);
    check("ign_result", 32'(result), 32'h96);
    check("ign_carry", 32'(carry_out), 32'd0);

    // Start held high: back-to-back operations every 10 clocks.
    start_op(8'h01, 8'h02, 1'b0, 1'b1);
    wait_done("hold1", lat);
    t1 = cyc;
    check("hold1_result", 32'(result), 32'h03);
    @(posedge clk);
    #1;
    check("hold1_done_one_cycle", 32'(done), 32'd0);
    wait_done("hold2", lat);
    t2 = cyc;
    start = 1'b0;
    check("hold_spacing", 32'(t2 - t1), 32'd10);
    check("hold2_result", 32'(result), 32'h03);

    // Reset mid-RUN after 4 bits.
    start_op(8'hAA, 8'h55, 1'b0, 1'b0);
    repeat (4) @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check("mid_rst_busy", 32'(busy), 32'd0);
    check("mid_rst_done", 32'(done), 32'd0);
    check("mid_rst_result", 32'(result), 32'd0);
    check("mid_rst_carry", 32'(carry_out), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    saw_done = 1'b0;
    repeat (12) begin
      @(posedge clk);
      #1;
      if (done) saw_done = 1'b1;
    end
    check("mid_rst_no_done", 32'(saw_done), 32'd0);
    do_op("post_rst_12_34", 8'h12, 8'h34, 1'b0, 8'h46, 1'b0);

    for (int i = 0; i < 1000; i++) begin
      ra = 8'($urandom_range(0, 255));
      rb = 8'($urandom_range(0, 255));
      rs = 1'($urandom_range(0, 1));
      if (rs) begin
        ref_r = ra - rb;
        ref_c = (ra >= rb);
      end else begin
        ref_sum = {1'b0, ra} + {1'b0, rb};
        ref_r   = ref_sum[7:0];
        ref_c   = ref_sum[8];
      end
      do_op("rand", ra, rb, rs, ref_r, ref_c);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/bitserial_add_ctrl.md
Name: bitserial_add_ctrl

Overview:
- Sequencer that time-shares one full-adder cell over a WIDTH-bit operand pair, LSB first, one bit per clock.
- The full-adder cell is built from two `ha` half adders plus an OR.
- Provides a start/busy/done handshake so multi-bit add and subtract reuse the single-bit datapath.
- Sits between a host register interface and the `ha`-based arithmetic cell.

Parameters:
- WIDTH, 8, operand/result width in bits (legal range 2..32).

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous active-low reset.
- start  input  1  request; sampled only in IDLE.
- sub  input  1  0 = add, 1 = subtract (op_a - op_b); sampled with start.
- op_a  input  WIDTH  operand A; sampled with start.
- op_b  input  WIDTH  operand B; sampled with start.
- busy  output  1  high in RUN and DONE.
- done  output  1  single-cycle pulse; result/carry_out valid.
- result  output  WIDTH  sum/difference, modulo 2^WIDTH.
- carry_out  output  1  add: carry out of the MSB; sub: 1 = no borrow (a >= b unsigned).

Behaviour:
- Reset (async assert, sync-to-clk deassert handled upstream):
  - State = IDLE; busy = 0, done = 0, result = 0, carry_out = 0.
  - Bit counter = 0; internal carry = 0; operand shift registers cleared.
- FSM states: IDLE, RUN, DONE.
- IDLE:
  - On an edge with start = 1, load a_sr = op_a and b_sr = (sub ? ~op_b : op_b).
  - Set carry = sub, counter = 0, state -> RUN.
  - start = 0: remain in IDLE; outputs hold.
- RUN, per edge:
  - fa_cell(a_sr[0], b_sr[0], carry) produces s and c.
  - Right-shift a_sr and b_sr.
  - Shift s into result at the MSB (result shifts right).
  - carry <= c; counter <= counter + 1.
  - On the edge where counter == WIDTH-1: state -> DONE, done <= 1, carry_out <= c.
- DONE:
  - Lasts exactly one cycle; the next edge sets done <= 0 and state -> IDLE.
- Latency: accept edge E0, bits processed on E1..E_WIDTH, done high in the cycle after E_WIDTH.
  - That is WIDTH clocks after accept; throughput one operation per WIDTH+2 clocks.
- Output validity:
  - result and carry_out are valid from the done cycle and hold until the next accepted start.
  - During RUN, result shows partial shifting values and is not valid.
- Boundary conditions:
  - start while busy (RUN or DONE): ignored, no queuing; operands are not re-sampled.
  - start held high continuously: a new operation is accepted in each IDLE cycle. Back-to-back spacing is WIDTH+2 clocks.
  - Operand changes during RUN: no effect, because operands are captured at accept.
  - Overflow: the add result wraps modulo 2^WIDTH; carry_out = 1 flags the wrap.
  - Subtract with a < b: two's-complement wrap, carry_out = 0.
  - Reset asserted mid-RUN: immediate return to reset values. No done pulse for the aborted operation; the first start after release runs normally.
- busy is a pure function of state (registered state, no combinational path from start).

Decomposition:
- Package bitserial_pkg:
  - typedef for the FSM state enum (IDLE, RUN, DONE).
  - localparam for the default WIDTH.
  - Counter width as $clog2(WIDTH).
- One sub-module fa_cell: two `ha` instances plus an OR for the carry (ports a, b, cin, sum, carry). This is the only combinational datapath.
- Controller: FSM, counter, shift registers and carry register in bitserial_add_ctrl.

Test Plan:
- WIDTH=8, add 0x00 + 0x00 -> result 0x00, carry_out 0, done high exactly 8 clocks after the accept edge for one cycle.
- Add 0xFF + 0x01 -> result 0x00, carry_out 1; add 0x5A + 0x3C -> result 0x96, carry_out 0.
- Sub 0x5A - 0x3C -> result 0x1E, carry_out 1; sub 0x3C - 0x5A -> result 0xE2, carry_out 0.
- Pulse start again at RUN bit 3 with op_a 0x11 -> ignored; the original 0x5A + 0x3C still yields 0x96. Start held high -> next done exactly 10 clocks later.
- rst_n low during RUN after 4 bits -> busy, done, result, carry_out all 0 asynchronously. After release, 0x12 + 0x34 -> 0x46, carry_out 0.
- Randomised 1000 add/sub ops versus reference model: result and carry_out match; done exactly once per accepted start.
